// File: rtl/aud_pkg.sv
// aud_pkg: shared widths and state encoding for the audio record/playback sequencer
package aud_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REC        = 3'd1,
    REC_PAUSE  = 3'd2,
    PLAY       = 3'd3,
    PLAY_PAUSE = 3'd4
  } aud_state_e;
endpackage

// File: rtl/aud_seq_ctrl_if.sv
// aud_seq_ctrl_if: recorder write request, DSP read address and shared SRAM port
//   rec_addr/rec_data/rec_we : recorder write request into the sequencer
//   dsp_addr                 : DSP current read address
//   sram_*                   : shared SRAM port driven by the sequencer
//   master = sequencer side, slave = recorder/DSP/SRAM side
interface aud_seq_ctrl_if;
  import aud_pkg::*;
  logic [ADDR_W-1:0] rec_addr;
  logic [DATA_W-1:0] rec_data;
  logic              rec_we;
  logic [ADDR_W-1:0] dsp_addr;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_we_n;
  logic              sram_oe_n;
  modport master (input rec_addr, rec_data, rec_we, dsp_addr,
                  output sram_addr, sram_wdata, sram_we_n, sram_oe_n);
  modport slave  (output rec_addr, rec_data, rec_we, dsp_addr,
                  input sram_addr, sram_wdata, sram_we_n, sram_oe_n);
endinterface

// File: rtl/aud_sram_mux.sv
// aud_sram_mux: steers the shared SRAM port from the registered sequencer state
//   i_state                        : registered sequencer state
//   i_rec_addr/i_rec_data/i_rec_we : recorder write request
//   i_dsp_addr                     : DSP read address
//   o_sram_*                       : SRAM address, write data, active-low write/output enables
module aud_sram_mux
  import aud_pkg::*;
(
  input  logic [2:0]        i_state,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  input  logic              i_rec_we,
  input  logic [ADDR_W-1:0] i_dsp_addr,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n
);
  logic rec, rec_any, play_any;
  assign rec      = i_state == REC;
  assign rec_any  = rec || i_state == REC_PAUSE;
  assign play_any = i_state == PLAY || i_state == PLAY_PAUSE;
  // write enable only in REC and output enable only in playback, so they can never overlap
  always_comb begin
    o_sram_addr  = rec_any ? i_rec_addr : play_any ? i_dsp_addr : '0;
    o_sram_wdata = rec ? i_rec_data : '0;
    o_sram_we_n  = ~(rec & i_rec_we);
    o_sram_oe_n  = ~play_any;
  end
endmodule

// File: rtl/aud_seq_ctrl.sv
// aud_seq_ctrl: key-driven record/playback sequencer with registered command pulses
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_key_*                  : one-cycle key pulses (priority stop > pause > play > rec)
//   o_rec_*                  : one-cycle recorder commands
//   o_dsp_*                  : one-cycle playback DSP commands
//   o_end_addr               : last written address of the current recording
//   o_state                  : current state encoding
//   bus                      : recorder request, DSP address and shared SRAM port
module aud_seq_ctrl
  import aud_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic [2:0]        o_state,
  aud_seq_ctrl_if.master    bus
);
  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_REC   = REC;
  localparam logic [2:0] S_RPAU  = REC_PAUSE;
  localparam logic [2:0] S_PLAY  = PLAY;
  localparam logic [2:0] S_PPAU  = PLAY_PAUSE;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [5:0]        cmd_q, cmd_d;
  logic              stop_k, pause_k, play_k, rec_k, wr, full, eor;
  // only the highest-priority key of a cycle is acted upon
  assign stop_k  = i_key_stop;
  assign pause_k = i_key_pause & ~i_key_stop;
  assign play_k  = i_key_play & ~i_key_pause & ~i_key_stop;
  assign rec_k   = i_key_rec & ~i_key_play & ~i_key_pause & ~i_key_stop;
  assign wr   = state_q == S_REC && bus.rec_we;
  assign full = wr && &bus.rec_addr;
  assign eor  = state_q == S_PLAY && bus.dsp_addr >= end_q;
  // cmd bits: {dsp_stop, dsp_pause, dsp_start, rec_stop, rec_pause, rec_start}
  always_comb begin
    state_d = state_q;
    end_d   = wr ? bus.rec_addr : end_q;
    cmd_d   = '0;
    case (state_q)
      S_IDLE: if (rec_k) begin
        state_d = S_REC;
        end_d   = '0;
        cmd_d   = 6'b000001;
      end else if (play_k && end_q != '0) begin
        state_d = S_PLAY;
        cmd_d   = 6'b001000;
      end
      S_REC: if (stop_k || full) begin
        state_d = S_IDLE;
        cmd_d   = 6'b000100;
      end else if (pause_k) begin
        state_d = S_RPAU;
        cmd_d   = 6'b000010;
      end
      S_RPAU: if (stop_k) begin
        state_d = S_IDLE;
        cmd_d   = 6'b000100;
      end else if (pause_k) begin
        state_d = S_REC;
        cmd_d   = 6'b000001;
      end
      S_PLAY: if (stop_k || eor) begin
        state_d = S_IDLE;
        cmd_d   = 6'b100000;
      end else if (pause_k) begin
        state_d = S_PPAU;
        cmd_d   = 6'b010000;
      end
      S_PPAU: if (stop_k) begin
        state_d = S_IDLE;
        cmd_d   = 6'b100000;
      end else if (pause_k) begin
        state_d = S_PLAY;
        cmd_d   = 6'b001000;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      end_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      end_q   <= end_d;
      cmd_q   <= cmd_d;
    end
  assign {o_dsp_stop, o_dsp_pause, o_dsp_start, o_rec_stop, o_rec_pause, o_rec_start} = cmd_q;
  assign o_end_addr = end_q;
  assign o_state    = state_q;
  aud_sram_mux u_mux (
    .i_state     (state_q),
    .i_rec_addr  (bus.rec_addr),
    .i_rec_data  (bus.rec_data),
    .i_rec_we    (bus.rec_we),
    .i_dsp_addr  (bus.dsp_addr),
    .o_sram_addr (bus.sram_addr),
    .o_sram_wdata(bus.sram_wdata),
    .o_sram_we_n (bus.sram_we_n),
    .o_sram_oe_n (bus.sram_oe_n)
  );
endmodule

// File: tb/tb_aud_seq_ctrl.sv
// tb_aud_seq_ctrl: directed and randomized check of aud_seq_ctrl against a behavioural model
module tb_aud_seq_ctrl;
  import aud_pkg::*;
  logic clk = 0, rst_n = 0;
  logic k_rec = 0, k_play = 0, k_pause = 0, k_stop = 0;
  logic rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop;
  logic [19:0] end_addr;
  logic [2:0]  state;
  aud_seq_ctrl_if bus();
  aud_seq_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_key_rec(k_rec), .i_key_play(k_play), .i_key_pause(k_pause), .i_key_stop(k_stop),
    .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
    .o_dsp_start(dsp_start), .o_dsp_pause(dsp_pause), .o_dsp_stop(dsp_stop),
    .o_end_addr(end_addr), .o_state(state), .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int cnt [6];
  int b [6];
  // model state: 0 idle, 1 rec, 2 rec paused, 3 play, 4 play paused
  int          m_st  = 0;
  logic [19:0] m_end = '0;
  logic [5:0]  m_p   = '0;
  // pulse index: 0 rec_start 1 rec_pause 2 rec_stop 3 dsp_start 4 dsp_pause 5 dsp_stop
  function automatic void step(input int st, input logic [19:0] e, input logic [3:0] k,
                               input logic we, input logic [19:0] ra, input logic [19:0] da,
                               output int ns, output logic [19:0] ne, output logic [5:0] p);
    string key;
    key = k[3] ? "stop" : k[2] ? "pause" : k[1] ? "play" : k[0] ? "rec" : "none";
    ns = st; ne = e; p = '0;
    if (st == 1 && we) ne = ra;
    if (st == 0) begin
      if (key == "rec") begin ns = 1; ne = 0; p[0] = 1; end
      else if (key == "play" && e != 0) begin ns = 3; p[3] = 1; end
    end else if (st == 1 || st == 2) begin
      if (key == "stop" || (st == 1 && we && ra == 20'hFFFFF)) begin ns = 0; p[2] = 1; end
      else if (key == "pause") begin ns = 3 - st; p[st == 1 ? 1 : 0] = 1; end
    end else begin
      if (key == "stop" || (st == 3 && da >= e)) begin ns = 0; p[5] = 1; end
      else if (key == "pause") begin ns = 7 - st; p[st == 3 ? 4 : 3] = 1; end
    end
  endfunction
  always @(posedge clk or negedge rst_n) begin : model
    int ns; logic [19:0] ne; logic [5:0] p;
    if (!rst_n) begin
      m_st <= 0; m_end <= '0; m_p <= '0;
    end else begin
      step(m_st, m_end, {k_stop, k_pause, k_play, k_rec}, bus.rec_we, bus.rec_addr, bus.dsp_addr, ns, ne, p);
      m_st <= ns; m_end <= ne; m_p <= p;
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask
  task automatic compare_all();
    logic [5:0]  d;
    logic [19:0] ea;
    d  = {dsp_stop, dsp_pause, dsp_start, rec_stop, rec_pause, rec_start};
    ea = (m_st == 1 || m_st == 2) ? bus.rec_addr : (m_st == 3 || m_st == 4) ? bus.dsp_addr : '0;
    chk("state", state, m_st);
    chk("end_addr", end_addr, m_end);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("pulse%0d", i), d[i], m_p[i]);
      cnt[i] += int'(d[i]);
    end
    chk("sram_addr", bus.sram_addr, ea);
    chk("sram_we_n", bus.sram_we_n, !(m_st == 1 && bus.rec_we));
    chk("sram_oe_n", bus.sram_oe_n, !(m_st == 3 || m_st == 4));
    if (m_st == 1) chk("sram_wdata", bus.sram_wdata, bus.rec_data);
    if (!bus.sram_we_n && !bus.sram_oe_n) chk("we_oe_overlap", 1, 0);
  endtask
  // keys k = {stop, pause, play, rec}
  task automatic tick(input logic [3:0] k, input logic we, input logic [19:0] ra,
                      input logic [15:0] rd, input logic [19:0] da);
    {k_stop, k_pause, k_play, k_rec} = k;
    bus.rec_we = we; bus.rec_addr = ra; bus.rec_data = rd; bus.dsp_addr = da;
    @(negedge clk);
    compare_all();
    #1;
  endtask
  task automatic reset_mid();
    {k_stop, k_pause, k_play, k_rec} = 4'b0;
    b = cnt;
    rst_n = 0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_end", end_addr, 0);
    chk("rst_pulses", {dsp_stop, dsp_pause, dsp_start, rec_stop, rec_pause, rec_start}, 0);
    chk("rst_we_n", bus.sram_we_n, 1);
    chk("rst_oe_n", bus.sram_oe_n, 1);
    chk("rst_addr", bus.sram_addr, 0);
    @(negedge clk);
    compare_all();
    #1;
    rst_n = 1;
    tick(4'b0, 0, 0, 0, 0);
    chk("rst_release_state", state, 0);
    chk("rst_no_stop", cnt[2] + cnt[5] - b[2] - b[5], 0);
  endtask
  initial begin
    logic [3:0]  k;
    logic [19:0] ra;
    bus.rec_addr = '0; bus.rec_data = '0; bus.rec_we = 0; bus.dsp_addr = '0;
    repeat (3) @(negedge clk);
    chk("init_state", state, 0);
    chk("init_end", end_addr, 0);
    chk("init_we_n", bus.sram_we_n, 1);
    chk("init_oe_n", bus.sram_oe_n, 1);
    #1 rst_n = 1;
    // play with nothing recorded
    b = cnt;
    tick(4'b0010, 0, 0, 0, 0);
    chk("empty_play_state", state, 0);
    chk("empty_play_start", cnt[3] - b[3], 0);
    // record ten samples at 0..9
    b = cnt;
    tick(4'b0001, 0, 0, 0, 0);
    chk("rec_state", state, 1);
    chk("rec_start", rec_start, 1);
    for (int i = 0; i < 10; i++) begin
      tick(4'b0, 1, 20'(i), 16'(i * 3 + 1), 0);
      chk("rec_we_n", bus.sram_we_n, 0);
      chk("rec_oe_n", bus.sram_oe_n, 1);
    end
    tick(4'b0, 0, 9, 0, 0);
    chk("rec_idle_we_n", bus.sram_we_n, 1);
    chk("rec_end9", end_addr, 9);
    chk("rec_start_once", cnt[0] - b[0], 1);
    tick(4'b1000, 0, 9, 0, 0);
    chk("rec_stop_state", state, 0);
    chk("rec_stop_pulse", rec_stop, 1);
    chk("rec_stop_end", end_addr, 9);
    // play back to the end of the recording
    b = cnt;
    tick(4'b0010, 0, 0, 0, 0);
    chk("play_state", state, 3);
    chk("play_start", dsp_start, 1);
    for (int i = 0; i < 10; i++) begin
      tick(4'b0, 0, 0, 0, 20'(i));
      chk("play_ramp_state", state, i == 9 ? 0 : 3);
      chk("play_ramp_oe_n", bus.sram_oe_n, i == 9 ? 1 : 0);
    end
    chk("play_start_once", cnt[3] - b[3], 1);
    chk("play_stop_once", cnt[5] - b[5], 1);
    tick(4'b0, 0, 0, 0, 9);
    chk("play_end_idle", state, 0);
    // pause and resume playback
    b = cnt;
    tick(4'b0010, 0, 0, 0, 0);
    tick(4'b0100, 0, 0, 0, 0);
    chk("ppause_state", state, 4);
    chk("ppause_pulse", dsp_pause, 1);
    tick(4'b0100, 0, 0, 0, 0);
    chk("presume_state", state, 3);
    chk("presume_pulse", dsp_start, 1);
    chk("presume_starts", cnt[3] - b[3], 2);
    chk("presume_pauses", cnt[4] - b[4], 1);
    // stop+pause+play together
    b = cnt;
    tick(4'b1110, 0, 0, 0, 0);
    tick(4'b0, 0, 0, 0, 0);
    chk("multi_state", state, 0);
    chk("multi_stops", cnt[5] - b[5], 1);
    chk("multi_pauses", cnt[4] - b[4], 0);
    // memory full
    tick(4'b0001, 0, 0, 0, 0);
    chk("full_clr_end", end_addr, 0);
    tick(4'b0, 1, 5, 16'h1234, 0);
    chk("full_end5", end_addr, 5);
    tick(4'b0, 1, 20'hFFFFF, 16'hBEEF, 0);
    chk("full_state", state, 0);
    chk("full_end", end_addr, 20'hFFFFF);
    chk("full_stop", rec_stop, 1);
    // reset in the middle of playback
    tick(4'b0010, 0, 0, 0, 0);
    tick(4'b0, 0, 0, 0, 100);
    chk("midplay_state", state, 3);
    reset_mid();
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      k  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      ra = ($urandom_range(0, 63) == 0) ? 20'hFFFFF : 20'($urandom_range(0, 40));
      if ($urandom_range(0, 499) == 0) reset_mid();
      tick(k, 1'($urandom), ra, 16'($urandom), 20'($urandom_range(0, 40)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aud_seq_ctrl.md
AUD_SEQ_CTRL -- requirements
Module: aud_seq_ctrl

Interface
REQ-001 SHALL have port i_clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports i_key_rec, i_key_play, i_key_pause, i_key_stop  input  1 each  debounced one-cycle key pulses.
REQ-004 SHALL have ports o_rec_start, o_rec_pause, o_rec_stop  output  1 each  one-cycle command pulses to the recorder.
REQ-005 SHALL have ports i_rec_addr  input  20, i_rec_data  input  16, i_rec_we  input  1  recorder write request (address, sample, strobe).
REQ-006 SHALL have ports o_dsp_start, o_dsp_pause, o_dsp_stop  output  1 each  one-cycle command pulses to the playback DSP.
REQ-007 SHALL have port i_dsp_addr  input  20  DSP current read address.
REQ-008 SHALL have ports o_sram_addr  output  20, o_sram_wdata  output  16, o_sram_we_n  output  1, o_sram_oe_n  output  1  shared SRAM port.
REQ-009 SHALL have port o_end_addr  output  20  last written address of current recording.
REQ-010 SHALL have port o_state  output  3  current state encoding, for display.

Function
REQ-011 SHALL implement states IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4.
REQ-012 SHALL decode key priority per cycle as stop > pause > play > rec; lower-priority simultaneous keys ignored.
REQ-013 SHALL transition IDLE+rec -> REC, clear end_addr to 0, pulse o_rec_start next cycle.
REQ-014 SHALL transition IDLE+play -> PLAY and pulse o_dsp_start only when end_addr != 0; otherwise stay IDLE, no pulse.
REQ-015 SHALL toggle REC<->REC_PAUSE on pause (pulse o_rec_pause entering REC_PAUSE, o_rec_start leaving it); PLAY<->PLAY_PAUSE likewise with o_dsp_pause/o_dsp_start.
REQ-016 SHALL, on stop in REC/REC_PAUSE, go IDLE and pulse o_rec_stop; in PLAY/PLAY_PAUSE, go IDLE and pulse o_dsp_stop; stop in IDLE is a no-op.
REQ-017 SHALL ignore rec keys while in PLAY/PLAY_PAUSE and play keys while in REC/REC_PAUSE.
REQ-018 SHALL register end_addr <= i_rec_addr on every cycle with state REC and i_rec_we=1.
REQ-019 SHALL, when a REC write occurs at i_rec_addr=20'hFFFFF (memory full), set end_addr=20'hFFFFF, go IDLE, pulse o_rec_stop.
REQ-020 SHALL, in PLAY when i_dsp_addr >= end_addr, go IDLE and pulse o_dsp_stop (end of recording); a stop key the same cycle yields a single o_dsp_stop.
REQ-021 SHALL register all command pulses: pulse asserted exactly one cycle, the cycle after the triggering key/condition.
REQ-022 SHALL drive SRAM combinationally from registered state: REC -> addr=i_rec_addr, wdata=i_rec_data, we_n=~i_rec_we, oe_n=1; REC_PAUSE -> addr=i_rec_addr, we_n=1, oe_n=1; PLAY/PLAY_PAUSE -> addr=i_dsp_addr, we_n=1, oe_n=0; IDLE -> addr=0, we_n=1, oe_n=1.
REQ-023 SHALL never assert o_sram_we_n=0 and o_sram_oe_n=0 in the same cycle.
REQ-024 SHALL hold o_end_addr stable across PLAY, pause and IDLE; only REQ-013/018/019 modify it.

Reset
REQ-025 SHALL, on i_rst_n=0, immediately force state IDLE, end_addr=0, all command pulses 0, o_sram_we_n=1, o_sram_oe_n=1, o_sram_addr=0.
REQ-026 SHALL, on reset mid-REC or mid-PLAY, emit no stop pulse; first cycle after release is IDLE.

Structure
REQ-027 SHALL place state enum, SRAM address width (20) and data width (16) in shared package aud_pkg.
REQ-028 SHALL instantiate one sub-module aud_sram_mux implementing REQ-022/023, keeping the FSM in aud_seq_ctrl.

Verification
REQ-029 SHALL cover: reset, rec pulse, 10 writes at addr 0..9 -> o_rec_start 1 cycle later, we_n follows i_rec_we, o_end_addr=9.
REQ-030 SHALL cover: after REQ-029, play, i_dsp_addr ramps 0..9 -> o_dsp_start once, oe_n=0, at addr 9 one o_dsp_stop, state IDLE.
REQ-031 SHALL cover: play with end_addr=0 after reset -> no o_dsp_start, state stays 0.
REQ-032 SHALL cover: PLAY, pause, pause -> PLAY_PAUSE then PLAY, o_dsp_pause then o_dsp_start, each 1 cycle.
REQ-033 SHALL cover: simultaneous stop+pause+play in PLAY -> one o_dsp_stop, no pause pulse, IDLE.
REQ-034 SHALL cover: REC write at 20'hFFFFF -> o_end_addr=FFFFF, o_rec_stop, IDLE; and i_rst_n low mid-PLAY -> IDLE, no stop pulse.
